// File: rtl/comp_arbiter.sv
// comp_arbiter: round-robin arbiter and sequencer owning one shared WIDTH-bit magnitude comparator.
// Build macro COMP_ARB_SIGNED_EN selects two's-complement ordering; default build compares unsigned.
//
// state  | meaning
// S_IDLE | arbitrate between req0/req1, grant is combinational this cycle
// S_CMP  | compare captured operands, register e/l/g and rsp_id
// S_RESP | rsp_vld pulse, flags valid
module comp_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             rsp_vld,
  output logic             rsp_id,
  output logic             e,
  output logic             l,
  output logic             g
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic             id;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cmp_gt;

  assign cmp_eq = (op_x == op_y);
`ifdef COMP_ARB_SIGNED_EN
  assign cmp_lt = ($signed(op_x) < $signed(op_y));
  assign cmp_gt = ($signed(op_x) > $signed(op_y));
`else
  assign cmp_lt = (op_x < op_y);
  assign cmp_gt = (op_x > op_y);
`endif

  // Grants are gated by rst_n so they read zero while reset is held.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (rst_n) begin
          if (req0 && (!req1 || !ptr)) gnt0 = 1'b1;
          else if (req1)               gnt1 = 1'b1;
          if (req0 || req1) state_nxt = S_CMP;
        end
      end
      S_CMP:   state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign rsp_vld = (state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ptr    <= 1'b0;
      id     <= 1'b0;
      op_x   <= '0;
      op_y   <= '0;
      rsp_id <= 1'b0;
      e      <= 1'b0;
      l      <= 1'b0;
      g      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt0 || gnt1) begin
        op_x <= gnt1 ? x1 : x0;
        op_y <= gnt1 ? y1 : y0;
        id   <= gnt1;
        ptr  <= gnt0;
      end
      if (state == S_CMP) begin
        e      <= cmp_eq;
        l      <= cmp_lt;
        g      <= cmp_gt;
        rsp_id <= id;
      end
    end
  end

endmodule

// File: tb/tb_comp_arbiter.sv
// Self-checking bench for comp_arbiter: directed scenarios plus randomized traffic against a schedule model.
// Honors COMP_ARB_SIGNED_EN to pick the expected ordering.
module tb_comp_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic         gnt0, gnt1, busy, rsp_vld, rsp_id, e, l, g;

  int errors = 0;
  int checks = 0;

  comp_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .x0(x0), .y0(y0),
    .req1(req1), .x1(x1), .y1(y1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .rsp_vld(rsp_vld),
    .rsp_id(rsp_id), .e(e), .l(l), .g(g)
  );

  always #5 clk = ~clk;

  // Ordering of two operands as the spec defines it, using plain integers.
  function automatic logic [2:0] ref_elg(input logic [W-1:0] a, input logic [W-1:0] b);
    int va, vb;
    va = int'(a);
    vb = int'(b);
`ifdef COMP_ARB_SIGNED_EN
    if (va >= (1 << (W - 1))) va = va - (1 << W);
    if (vb >= (1 << (W - 1))) vb = vb - (1 << W);
`endif
    return {va == vb, va < vb, va > vb};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    checks++;
    if ({gnt0, gnt1, busy, rsp_vld, rsp_id, e, l, g} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000", {gnt0, gnt1, busy, rsp_vld, rsp_id, e, l, g});
    end
  endtask

  task automatic test_unsigned_lt();
    req0 = 1'b1; x0 = 4'b1100; y0 = 4'b1111; req1 = 1'b0;
    do_reset();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL lt_grant: got %b expected 10", {gnt0, gnt1});
    end
    @(negedge clk); req0 = 1'b0; #1;
    checks++;
    if ({busy, rsp_vld} !== 2'b10) begin
      errors++; $display("FAIL lt_cmp_cycle: busy,rsp_vld got %b expected 10", {busy, rsp_vld});
    end
    next_cycle();
    checks++;
    if ({rsp_vld, rsp_id, e, l, g} !== 5'b10010) begin
      errors++; $display("FAIL lt_response: got %b expected 10010", {rsp_vld, rsp_id, e, l, g});
    end
  endtask

  task automatic test_equal();
    req0 = 1'b0; req1 = 1'b1; x1 = 4'b1111; y1 = 4'b1111;
    do_reset();
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      errors++; $display("FAIL eq_grant: got %b expected 01", {gnt0, gnt1});
    end
    @(negedge clk); req1 = 1'b0; #1;
    next_cycle();
    checks++;
    if ({rsp_vld, rsp_id, e, l, g} !== 5'b11100) begin
      errors++; $display("FAIL eq_response: got %b expected 11100", {rsp_vld, rsp_id, e, l, g});
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_gnt;
    logic [4:0] exp_rsp;
    req0 = 1'b1; x0 = 4'b1111; y0 = 4'b0000;
    req1 = 1'b1; x1 = 4'b0011; y1 = 4'b0011;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      exp_gnt = 2'b00;
      if (c % 3 == 0) exp_gnt = ((c / 3) % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({gnt0, gnt1} !== exp_gnt) begin
        errors++; $display("FAIL sim_grant c=%0d: got %b expected %b", c, {gnt0, gnt1}, exp_gnt);
      end
      if (c % 3 == 2) begin
        if (((c - 2) / 3) % 2 == 0) exp_rsp = {2'b10, ref_elg(4'b1111, 4'b0000)};
        else                        exp_rsp = {2'b11, 3'b100};
        checks++;
        if ({rsp_vld, rsp_id, e, l, g} !== exp_rsp) begin
          errors++; $display("FAIL sim_response c=%0d: got %b expected %b", c, {rsp_vld, rsp_id, e, l, g}, exp_rsp);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_signed_build();
    logic [2:0] exp_elg;
`ifdef COMP_ARB_SIGNED_EN
    exp_elg = 3'b010;
`else
    exp_elg = 3'b001;
`endif
    req0 = 1'b1; x0 = 4'b1111; y0 = 4'b0000; req1 = 1'b0;
    do_reset();
    @(negedge clk); req0 = 1'b0; #1;
    next_cycle();
    checks++;
    if ({rsp_vld, rsp_id, e, l, g} !== {2'b10, exp_elg}) begin
      errors++; $display("FAIL signed_order: got %b expected %b", {rsp_vld, rsp_id, e, l, g}, {2'b10, exp_elg});
    end
  endtask

  task automatic test_reset_in_cmp();
    req0 = 1'b1; x0 = 4'b1111; y0 = 4'b0000; req1 = 1'b0;
    do_reset();
    repeat (4) next_cycle();
    checks++;
    if ({busy, rsp_vld} !== 2'b10) begin
      errors++; $display("FAIL rst_pre_cmp: busy,rsp_vld got %b expected 10", {busy, rsp_vld});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, busy, rsp_vld, rsp_id, e, l, g} !== 8'b0) begin
      errors++;
      $display("FAIL rst_async_clear: got %b expected 00000000", {gnt0, gnt1, busy, rsp_vld, rsp_id, e, l, g});
    end
    req1 = 1'b1; x1 = 4'b0101; y1 = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, rsp_vld} !== 3'b100) begin
      errors++; $display("FAIL rst_first_grant: got %b expected 100", {gnt0, gnt1, rsp_vld});
    end
    next_cycle();
    checks++;
    if (rsp_vld !== 1'b0) begin
      errors++; $display("FAIL rst_no_stale_rsp: rsp_vld got %b expected 0", rsp_vld);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    req0 = 1'b0; req1 = 1'b1; x1 = 4'b0010; y1 = 4'b0001;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) next_cycle();
      checks++;
      if ({gnt0, gnt1, busy} !== ((c % 3 == 0) ? 3'b010 : 3'b001)) begin
        errors++;
        $display("FAIL b2b_c%0d: gnt0,gnt1,busy got %b expected %b", c, {gnt0, gnt1, busy},
                 (c % 3 == 0) ? 3'b010 : 3'b001);
      end
    end
    req1 = 1'b0;
  endtask

  typedef struct {
    int         cyc;
    logic       id;
    logic [2:0] elg;
  } resp_t;

  // Model: a compare occupies the shared unit for 3 cycles; winner alternates on contention.
  task automatic test_random();
    resp_t      q[$];
    int         next_free = 0;
    logic       m_ptr = 1'b0;
    logic       pend0 = 1'b0, pend1 = 1'b0;
    logic [1:0] exp_gnt;
    logic       exp_busy, exp_vld, win;
    logic [3:0] exp_out = 4'b0;
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      if (!pend0) begin
        req0 = ($urandom_range(0, 9) < 6);
        x0 = W'($urandom); y0 = ($urandom_range(0, 3) == 0) ? x0 : W'($urandom);
      end
      if (!pend1) begin
        req1 = ($urandom_range(0, 9) < 6);
        x1 = W'($urandom); y1 = ($urandom_range(0, 3) == 0) ? x1 : W'($urandom);
      end
      #1;
      exp_busy = (c < next_free);
      exp_gnt = 2'b00;
      if (!exp_busy && (req0 || req1)) begin
        win = (req0 && req1) ? m_ptr : req1;
        exp_gnt = win ? 2'b01 : 2'b10;
        next_free = c + 3;
        m_ptr = !win;
        q.push_back('{cyc: c + 2, id: win, elg: win ? ref_elg(x1, y1) : ref_elg(x0, y0)});
      end
      pend0 = req0 && !exp_gnt[1];
      pend1 = req1 && !exp_gnt[0];
      exp_vld = (q.size() > 0) && (q[0].cyc == c);
      if (exp_vld) begin
        exp_out = {q[0].id, q[0].elg};
        void'(q.pop_front());
      end
      checks++;
      if ({gnt0, gnt1, busy} !== {exp_gnt, exp_busy}) begin
        errors++;
        $display("FAIL rnd_grant c=%0d: gnt0,gnt1,busy got %b expected %b", c, {gnt0, gnt1, busy}, {exp_gnt, exp_busy});
      end
      checks++;
      if ({rsp_vld, rsp_id, e, l, g} !== {exp_vld, exp_out}) begin
        errors++;
        $display("FAIL rnd_resp c=%0d: got %b expected %b", c, {rsp_vld, rsp_id, e, l, g}, {exp_vld, exp_out});
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned_lt();
    test_equal();
    test_simultaneous();
    test_signed_build();
    test_reset_in_cmp();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
